// File: rtl/div_arb.sv
// div_arb: round-robin scheduler that shares one 16-bit divider between two requesters.
// Optional build macro DIV_ZERO_CHK_EN answers zero divisors locally without starting the divider.
module div_arb #(
    parameter int TMO_W = 5
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] dvd0,
    input  logic [15:0] dvd1,
    input  logic [15:0] dvs0,
    input  logic [15:0] dvs1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] div_M,
    output logic [15:0] div_Q,
    output logic        div_start,
    input  logic [31:0] div_result,
    input  logic        div_done,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [TMO_W-1:0] WDOG_MAX = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] WDOG_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             owner_r;
    logic             last_r;
    logic             pick1_s;
    logic [15:0]      op_m_r;
    logic [15:0]      op_q_r;
    logic [TMO_W-1:0] wdog_r;
    logic [TMO_W-1:0] wdog_inc_s;
    logic             tmo_s;
    logic             start_ok_s;
    logic             zero_hit_s;
    logic             gnt0_r;
    logic             gnt1_r;
    logic             done0_r;
    logic             done1_r;
    logic             div_start_r;
    logic [31:0]      rsp_data_r;
    logic             rsp_err_r;

    assign wdog_inc_s = wdog_r + WDOG_ONE;
    assign tmo_s      = (wdog_inc_s == WDOG_MAX);

`ifdef DIV_ZERO_CHK_EN
    logic zero_r;

    // Flag a zero divisor in ISSUE; WAIT then completes it one cycle later without the divider
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            zero_r <= 1'b0;
        end else if (state_r == ST_ISSUE) begin
            zero_r <= (op_m_r == 16'h0000);
        end else begin
            zero_r <= zero_r;
        end
    end

    assign start_ok_s = (op_m_r != 16'h0000);
    assign zero_hit_s = zero_r && (wdog_r == WDOG_ONE);
`else
    assign start_ok_s = 1'b1;
    assign zero_hit_s = 1'b0;
`endif

    // Round-robin pick: last_r is the requester served last, so the other one wins a tie
    always_comb begin
        pick1_s = 1'b0;
        if (req0 && req1) begin
            pick1_s = ~last_r;
        end else if (req1) begin
            pick1_s = 1'b1;
        end else begin
            pick1_s = 1'b0;
        end
    end

    // Next-state decode; a divider completion beats a coincident timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (div_done || zero_hit_s || tmo_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Controller state, operand capture, pulses and response registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            last_r      <= 1'b1;
            op_m_r      <= 16'h0000;
            op_q_r      <= 16'h0000;
            wdog_r      <= {TMO_W{1'b0}};
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            div_start_r <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            div_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner_r <= pick1_s;
                        gnt0_r  <= ~pick1_s;
                        gnt1_r  <= pick1_s;
                        op_q_r  <= pick1_s ? dvd1 : dvd0;
                        op_m_r  <= pick1_s ? dvs1 : dvs0;
                    end
                end
                ST_ISSUE: begin
                    wdog_r      <= {TMO_W{1'b0}};
                    div_start_r <= start_ok_s;
                end
                ST_WAIT: begin
                    wdog_r <= wdog_inc_s;
                    if (div_done) begin
                        rsp_data_r <= div_result;
                        rsp_err_r  <= 1'b0;
                        done0_r    <= ~owner_r;
                        done1_r    <= owner_r;
                    end else if (zero_hit_s) begin
                        rsp_data_r <= {op_q_r, 16'hFFFF};
                        rsp_err_r  <= 1'b1;
                        done0_r    <= ~owner_r;
                        done1_r    <= owner_r;
                    end else if (tmo_s) begin
                        rsp_data_r <= 32'h0000_0000;
                        rsp_err_r  <= 1'b1;
                        done0_r    <= ~owner_r;
                        done1_r    <= owner_r;
                    end
                end
                ST_RESP: begin
                    last_r <= owner_r;
                end
                default: begin
                    last_r <= last_r;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign done0     = done0_r;
    assign done1     = done1_r;
    assign div_start = div_start_r;
    assign div_M     = op_m_r;
    assign div_Q     = op_q_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_div_arb.sv
// Self-checking bench for div_arb: behavioural divider stub plus a reference model of
// arbitration order, result values and latencies.
module tb_div_arb;

    localparam int TMO_W = 5;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req0, req1;
    logic [15:0] dvd0, dvd1, dvs0, dvs1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] div_M, div_Q;
    logic        div_start;
    logic [31:0] div_result = 32'h0;
    logic        div_done = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    bit last_srv = 1'b1;
    bit stub_en = 1'b1;
    int stub_cnt = 0;

    always #5 clk = ~clk;

    div_arb #(.TMO_W(TMO_W)) dut (
        .clk(clk), .n_rst(n_rst),
        .req0(req0), .req1(req1),
        .dvd0(dvd0), .dvd1(dvd1), .dvs0(dvs0), .dvs1(dvs1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .div_M(div_M), .div_Q(div_Q), .div_start(div_start),
        .div_result(div_result), .div_done(div_done), .busy(busy)
    );

    // Divider arithmetic: {remainder, quotient}; a zero divisor yields {dividend, all-ones}
    function automatic logic [31:0] ref_div(input logic [15:0] q, input logic [15:0] m);
        if (m == 16'h0000) return {q, 16'hFFFF};
        else return {16'(q % m), 16'(q / m)};
    endfunction

    // Divider stub: samples start, raises done 16 edges later, reading M/Q only at completion
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (div_start && stub_en) begin
            stub_cnt <= 16;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                div_done   <= 1'b1;
                div_result <= ref_div(div_Q, div_M);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gnt"}, {30'h0, gnt1, gnt0}, 32'h0);
        chk({tag, "_done"}, {30'h0, done1, done0}, 32'h0);
        chk({tag, "_start"}, {31'h0, div_start}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_data"}, rsp_data, 32'h0);
        chk({tag, "_err"}, {31'h0, rsp_err}, 32'h0);
        chk({tag, "_M"}, {16'h0, div_M}, 32'h0);
        chk({tag, "_Q"}, {16'h0, div_Q}, 32'h0);
    endtask

    // One transaction from requester r; expectations come from the model, not the DUT
    task automatic single_op(input bit r, input logic [15:0] dvd, input logic [15:0] dvs,
                             input bit stub_ok, input bit chg);
        logic [31:0] exp_data;
        logic [31:0] own;
        bit exp_err;
        int exp_lat, exp_starts, n, starts, start_at;
        bit stable;
        logic [1:0] g1;
        own = r ? 32'd2 : 32'd1;
        exp_starts = 1;
        exp_lat = 19;
        if (!stub_ok) begin
            exp_data = 32'h0;
            exp_err = 1'b1;
            exp_lat = 1 + (2 ** TMO_W - 1);
        end else if (dvs == 16'h0000) begin
`ifdef DIV_ZERO_CHK_EN
            exp_data = {dvd, 16'hFFFF};
            exp_err = 1'b1;
            exp_lat = 3;
            exp_starts = 0;
`else
            exp_data = ref_div(dvd, dvs);
            exp_err = 1'b0;
`endif
        end else begin
            exp_data = ref_div(dvd, dvs);
            exp_err = 1'b0;
        end
        stub_en = stub_ok;
        @(negedge clk);
        req0 = ~r; req1 = r;
        if (r) begin dvd1 = dvd; dvs1 = dvs; end
        else begin dvd0 = dvd; dvs0 = dvs; end
        @(negedge clk);
        chk("gnt", {30'h0, gnt1, gnt0}, own);
        req0 = 1'b0; req1 = 1'b0;
        starts = 0; start_at = -1; stable = 1'b1; g1 = 2'b00; n = 0;
        while (n < 64) begin
            if (chg) begin
                if (r) begin dvd1 = 16'($urandom); dvs1 = 16'($urandom); end
                else begin dvd0 = 16'($urandom); dvs0 = 16'($urandom); end
            end
            @(negedge clk);
            n++;
            if (n == 1) g1 = {gnt1, gnt0};
            if (div_start) begin starts++; start_at = n; end
            if (div_M !== dvs || div_Q !== dvd) stable = 1'b0;
            if (done0 || done1) break;
        end
        chk("gnt_width", {30'h0, g1}, 32'h0);
        chk("start_cnt", starts, exp_starts);
        if (exp_starts == 1) chk("start_at", start_at, 32'd1);
        chk("latency", n, exp_lat);
        chk("done_owner", {30'h0, done1, done0}, own);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
        chk("op_stable", {31'h0, stable}, 32'd1);
        @(negedge clk);
        chk("done_width", {30'h0, done1, done0}, 32'h0);
        chk("rsp_hold", rsp_data, exp_data);
        last_srv = r;
        stub_en = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k, done_seen, busy_seen;
        bit w, r;
        logic [15:0] a, b;
        n_rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        dvd0 = 16'h0; dvd1 = 16'h0; dvs0 = 16'h0; dvs1 = 16'h0;
        #1 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst");
        n_rst = 1'b1;

        single_op(1'b0, 16'd100, 16'd7, 1'b1, 1'b0);

        // Both requesters held high from reset: grants must alternate starting with 0
        @(negedge clk);
        n_rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        dvd0 = 16'hFFFF; dvs0 = 16'h0001; dvd1 = 16'd1000; dvs1 = 16'd3;
        last_srv = 1'b1;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            w = ~last_srv;
            k = 0;
            while (!(gnt0 || gnt1) && k < 64) begin @(negedge clk); k++; end
            chk("rr_gnt", {30'h0, gnt1, gnt0}, w ? 32'd2 : 32'd1);
            k = 0;
            while (!(done0 || done1) && k < 64) begin @(negedge clk); k++; end
            chk("rr_done", {30'h0, done1, done0}, w ? 32'd2 : 32'd1);
            chk("rr_data", rsp_data, w ? 32'h0001_014D : 32'h0000_FFFF);
            last_srv = w;
            if (t == 2) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
        end
        k = 0;
        while (busy && k < 64) begin @(negedge clk); k++; end
        chk("rr_idle", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            r = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom_range(1, 65535));
            single_op(r, a, b, 1'b1, 1'b0);
        end

        single_op(1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0);

        single_op(1'b0, 16'd50, 16'd5, 1'b0, 1'b0);
        single_op(1'b1, 16'd77, 16'd10, 1'b1, 1'b0);

        single_op(1'b0, 16'd40000, 16'd123, 1'b1, 1'b1);

        // Reset during WAIT: outputs clear, the stale divider completion must be ignored
        @(negedge clk);
        req0 = 1'b1; dvd0 = 16'd1000; dvs0 = 16'd9;
        @(negedge clk);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", {31'h0, busy}, 32'd1);
        n_rst = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        n_rst = 1'b1;
        done_seen = 0; busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done0 || done1) done_seen++;
            if (busy) busy_seen++;
        end
        chk("stale_done", done_seen, 32'h0);
        chk("stale_busy", busy_seen, 32'h0);
        last_srv = 1'b1;
        single_op(1'b0, 16'd1000, 16'd9, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
